hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
- Second-generation hazard block for the 5-stage pipeline (F/D/E/M/W).
- Generates E-stage operand forward selects for NUM_SRC source channels, D-stage branch-compare forwards, and F/D stall plus E flush.
- Owns a countdown scoreboard for the multi-cycle mult/div unit, so HI/LO consumers stall until the result is ready.
- Sits beside the datapath; all data muxes stay in the datapath.

Parameters:
- NUM_SRC, 2, source-operand channels per stage (rs, rt, ...).
- AW, 5, register address width.
- MUL_LAT, 5, mult busy cycles after issue (>=1).
- DIV_LAT, 10, div busy cycles after issue (>=1).
- CW, 4, countdown counter width; must hold max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- src_d  in  NUM_SRC*AW  D-stage source regs; channel i at [i*AW +: AW]
- use_d  in  NUM_SRC  channel i of D instruction is read
- br_d  in  1  D instruction is a branch comparing its sources in D
- md_use_d  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- src_e  in  NUM_SRC*AW  E-stage source regs
- dst_e  in  AW  E destination
- wen_e  in  1  E writes the register file
- load_e  in  1  E is a load
- md_start_e  in  1  E issues mult/div this cycle
- md_div_e  in  1  1 = div, 0 = mult (qualified by md_start_e)
- dst_m  in  AW  M destination
- wen_m  in  1  M writes the register file
- load_m  in  1  M is a load
- dst_w  in  AW  W destination
- wen_w  in  1  W writes the register file
- fwd_e  out  NUM_SRC*2  per channel: 00 RF/pipe reg, 10 from M, 01 from W
- fwd_d  out  NUM_SRC  per channel: 1 = take M ALU result for branch compare
- stall_f  out  1  hold PC
- stall_d  out  1  hold F/D register
- flush_e  out  1  insert bubble into D/E register
- md_busy  out  1  mult/div result not yet ready

Behaviour:
- fwd_e channel i:
  - 10 if wen_m && dst_m!=0 && dst_m==src_e[i].
  - Else 01 if wen_w && dst_w!=0 && dst_w==src_e[i].
  - Else 00. M beats W.
  - Purely combinational from current inputs.
- fwd_d[i] = wen_m && !load_m && dst_m!=0 && dst_m==src_d[i].
- hz_load: load_e && dst_e!=0 && some use_d[i] with src_d[i]==dst_e.
- hz_br: br_d && use_d[i] && src_d[i]!=0, with either:
  - (wen_e && dst_e==src_d[i]), or
  - (load_m && wen_m && dst_m==src_d[i]).
- hz_md: md_use_d && (md_busy || md_start_e).
- stall_f = stall_d = flush_e = hz_load | hz_br | hz_md. Combinational; no extra latency.
- Register $0 never matches any hazard or forward.
- Scoreboard counter cnt (CW bits):
  - Reset: cnt=0.
  - On md_start_e, next cnt = md_div_e ? DIV_LAT : MUL_LAT. Reload wins over decrement; a start while busy restarts the count.
  - Otherwise, if cnt!=0, cnt decrements by 1 per cycle, saturating at 0.
  - md_busy = (cnt!=0), registered-derived, so it is first high the cycle after md_start_e.
  - Mult issued at edge k: busy for edges k+1 .. k+MUL_LAT, low afterwards.
- Reset (rst_n low, any time): cnt=0 immediately; md_busy=0. Combinational outputs follow inputs. An in-flight mult/div is abandoned.
- Simultaneous hazards: one OR'd stall; no priority needed.
- flush_e during a stall does not cancel a md_start_e already in E.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, adds outputs:
  - stall_cycles (32): cycles with stall_d=1.
  - load_use_cnt (32): cycles with hz_load=1.
  - md_wait_cnt (32): cycles with hz_md=1.
- All three counters: reset to 0, wrap at 2^32, plus input stats_clr that zeros all three synchronously, with clr priority.
- When undefined, the ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- E/M/W forwarding:
  - wen_m=1, dst_m=8, src_e ch0=8 and ch1=9; wen_w=1, dst_w=9 -> fwd_e={01,10}.
  - dst_m=0 with src_e=0 -> 00.
- Load-use: load_e=1, dst_e=4, src_d ch1=4, use_d=2'b10 -> stall_f=stall_d=flush_e=1 for exactly 1 cycle. Next cycle load_m=1 -> no stall, and fwd_e ch1=10 once in E.
- Branch: br_d=1, src_d ch0=3, wen_e=1, dst_e=3 -> stall 1 cycle. Then wen_m, dst_m=3, !load_m -> fwd_d[0]=1, stall=0.
- Mult then mflo:
  - md_start_e=1, md_div_e=0 at edge 0; md_use_d=1 held -> stall on cycles 0..5.
  - md_busy high on edges 1..5, stall released on edge 6.
- Div latency: DIV_LAT=10, start at edge 0 -> md_busy=1 edges 1..10, 0 at edge 11. A second start at edge 3 reloads -> busy until edge 13.
- Reset mid-div: rst_n low at edge 4 -> md_busy=0 asynchronously, stall from hz_md=0. With HAZARD_STATS_EN, all counters read 0.

Source files
------------

// File: rtl/hazard_forward_unit_if.sv
// Signal bundle between the pipeline datapath and hazard_forward_unit.
// HAZARD_STATS_EN adds the stall-statistics counters and their clear input.
interface hazard_forward_unit_if #(
  parameter int NUM_SRC = 2,
  parameter int AW      = 5
);
  logic [NUM_SRC*AW-1:0] src_d;
  logic [NUM_SRC-1:0]    use_d;
  logic                  br_d;
  logic                  md_use_d;
  logic [NUM_SRC*AW-1:0] src_e;
  logic [AW-1:0]         dst_e;
  logic                  wen_e;
  logic                  load_e;
  logic                  md_start_e;
  logic                  md_div_e;
  logic [AW-1:0]         dst_m;
  logic                  wen_m;
  logic                  load_m;
  logic [AW-1:0]         dst_w;
  logic                  wen_w;
  logic [NUM_SRC*2-1:0]  fwd_e;
  logic [NUM_SRC-1:0]    fwd_d;
  logic                  stall_f;
  logic                  stall_d;
  logic                  flush_e;
  logic                  md_busy;
`ifdef HAZARD_STATS_EN
  logic                  stats_clr;
  logic [31:0]           stall_cycles;
  logic [31:0]           load_use_cnt;
  logic [31:0]           md_wait_cnt;
`endif

  modport slave (
`ifdef HAZARD_STATS_EN
    input  stats_clr,
    output stall_cycles, load_use_cnt, md_wait_cnt,
`endif
    input  src_d, use_d, br_d, md_use_d, src_e, dst_e, wen_e, load_e,
           md_start_e, md_div_e, dst_m, wen_m, load_m, dst_w, wen_w,
    output fwd_e, fwd_d, stall_f, stall_d, flush_e, md_busy
  );

  modport master (
`ifdef HAZARD_STATS_EN
    output stats_clr,
    input  stall_cycles, load_use_cnt, md_wait_cnt,
`endif
    output src_d, use_d, br_d, md_use_d, src_e, dst_e, wen_e, load_e,
           md_start_e, md_div_e, dst_m, wen_m, load_m, dst_w, wen_w,
    input  fwd_e, fwd_d, stall_f, stall_d, flush_e, md_busy
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Forwarding selects, load-use/branch/mult-div stall logic and mult/div busy countdown.
// Define HAZARD_STATS_EN to add the stall/load-use/md-wait cycle counters.
module hazard_forward_unit #(
  parameter int NUM_SRC = 2,
  parameter int AW      = 5,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CW      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hazard_forward_unit_if.slave  bus
);

  localparam logic [CW-1:0] MulLoad = CW'(MUL_LAT);
  localparam logic [CW-1:0] DivLoad = CW'(DIV_LAT);

  logic [CW-1:0]        cnt;
  logic                 mdBusy;
  logic                 hzLoad;
  logic                 hzBr;
  logic                 hzMd;
  logic                 stall;
  logic [NUM_SRC*2-1:0] fwdE;
  logic [NUM_SRC-1:0]   fwdD;

  always_comb begin
    fwdE   = '0;
    fwdD   = '0;
    hzLoad = 1'b0;
    hzBr   = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (bus.wen_m && bus.dst_m != '0 && bus.dst_m == bus.src_e[i*AW +: AW])
        fwdE[i*2 +: 2] = 2'b10;
      else if (bus.wen_w && bus.dst_w != '0 && bus.dst_w == bus.src_e[i*AW +: AW])
        fwdE[i*2 +: 2] = 2'b01;

      fwdD[i] = bus.wen_m && !bus.load_m && bus.dst_m != '0 &&
                bus.dst_m == bus.src_d[i*AW +: AW];

      if (bus.load_e && bus.dst_e != '0 && bus.use_d[i] &&
          bus.src_d[i*AW +: AW] == bus.dst_e)
        hzLoad = 1'b1;

      // Branch compares in D: wait for anything still in E, or a load still in M.
      if (bus.br_d && bus.use_d[i] && bus.src_d[i*AW +: AW] != '0 &&
          ((bus.wen_e && bus.dst_e == bus.src_d[i*AW +: AW]) ||
           (bus.load_m && bus.wen_m && bus.dst_m == bus.src_d[i*AW +: AW])))
        hzBr = 1'b1;
    end
  end

  assign mdBusy = (cnt != '0);
  assign hzMd   = bus.md_use_d && (mdBusy || bus.md_start_e);
  assign stall  = hzLoad | hzBr | hzMd;

  // A new issue always reloads, even while a previous op is still counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (bus.md_start_e)
      cnt <= bus.md_div_e ? DivLoad : MulLoad;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign bus.fwd_e   = fwdE;
  assign bus.fwd_d   = fwdD;
  assign bus.stall_f = stall;
  assign bus.stall_d = stall;
  assign bus.flush_e = stall;
  assign bus.md_busy = mdBusy;

`ifdef HAZARD_STATS_EN
  logic [31:0] stallCycles;
  logic [31:0] loadUseCnt;
  logic [31:0] mdWaitCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCycles <= '0;
      loadUseCnt  <= '0;
      mdWaitCnt   <= '0;
    end else if (bus.stats_clr) begin
      stallCycles <= '0;
      loadUseCnt  <= '0;
      mdWaitCnt   <= '0;
    end else begin
      stallCycles <= stallCycles + {31'd0, stall};
      loadUseCnt  <= loadUseCnt + {31'd0, hzLoad};
      mdWaitCnt   <= mdWaitCnt + {31'd0, hzMd};
    end
  end

  assign bus.stall_cycles = stallCycles;
  assign bus.load_use_cnt = loadUseCnt;
  assign bus.md_wait_cnt  = mdWaitCnt;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: vector table, mult/div/reset sequences, random vs model.
module tb_hazard_forward_unit;

  localparam int NS = 2;
  localparam int AWD = 5;

  logic clk;
  logic rst_n;

  hazard_forward_unit_if #(.NUM_SRC(NS), .AW(AWD)) bus ();

  hazard_forward_unit #(
    .NUM_SRC(NS), .AW(AWD), .MUL_LAT(5), .DIV_LAT(10), .CW(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [9:0] srcD;
    logic [1:0] useD;
    logic       brD;
    logic       mdUseD;
    logic [9:0] srcE;
    logic [4:0] dstE;
    logic       wenE;
    logic       loadE;
    logic       mdStart;
    logic       mdDiv;
    logic [4:0] dstM;
    logic       wenM;
    logic       loadM;
    logic [4:0] dstW;
    logic       wenW;
    logic [3:0] expFwdE;
    logic [1:0] expFwdD;
    logic       expStall;
  } vec_t;

  int nCmp = 0;
  int nBad = 0;

  // Model state: edge index, last mult/div issue edge and its latency.
  int edgeCnt   = 0;
  int lastStart = -100;
  int lastLat   = 0;
  logic [31:0] mStall = 0, mLoad = 0, mMd = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic applyVec(input vec_t v);
    bus.src_d = v.srcD;      bus.use_d = v.useD;      bus.br_d = v.brD;
    bus.md_use_d = v.mdUseD; bus.src_e = v.srcE;      bus.dst_e = v.dstE;
    bus.wen_e = v.wenE;      bus.load_e = v.loadE;    bus.md_start_e = v.mdStart;
    bus.md_div_e = v.mdDiv;  bus.dst_m = v.dstM;      bus.wen_m = v.wenM;
    bus.load_m = v.loadM;    bus.dst_w = v.dstW;      bus.wen_w = v.wenW;
  endtask

  function automatic logic modelBusy();
    return edgeCnt < lastStart + lastLat;
  endfunction

  function automatic int regOf(input logic [9:0] bits, input int ch);
    return int'((bits >> (ch * 5)) & 10'h1f);
  endfunction

  // Reference rules written over register numbers.
  function automatic logic [4:0] refHaz(input logic busy);
    int dE, dM, dW, s;
    logic ld, br, md;
    ld = 0; br = 0;
    dE = int'(bus.dst_e); dM = int'(bus.dst_m); dW = int'(bus.dst_w);
    for (int c = 0; c < NS; c++) begin
      s = regOf(bus.src_d, c);
      if (bus.load_e && dE != 0 && bus.use_d[c] && s == dE) ld = 1;
      if (bus.br_d && bus.use_d[c] && s != 0 &&
          ((bus.wen_e && dE == s) || (bus.load_m && bus.wen_m && dM == s))) br = 1;
    end
    md = bus.md_use_d && (busy || bus.md_start_e);
    return {ld | br | md, ld, br, md, 1'b0};
  endfunction

  function automatic logic [3:0] refFwdE();
    logic [3:0] r;
    int s;
    r = '0;
    for (int c = 0; c < NS; c++) begin
      s = regOf(bus.src_e, c);
      if (s != 0 && bus.wen_m && int'(bus.dst_m) == s) r[c*2 +: 2] = 2'b10;
      else if (s != 0 && bus.wen_w && int'(bus.dst_w) == s) r[c*2 +: 2] = 2'b01;
    end
    return r;
  endfunction

  function automatic logic [1:0] refFwdD();
    logic [1:0] r;
    int s;
    r = '0;
    for (int c = 0; c < NS; c++) begin
      s = regOf(bus.src_d, c);
      r[c] = s != 0 && bus.wen_m && !bus.load_m && int'(bus.dst_m) == s;
    end
    return r;
  endfunction

  task automatic tick();
    logic [4:0] h;
    h = refHaz(modelBusy());
    @(posedge clk);
    edgeCnt++;
    if (bus.md_start_e) begin
      lastStart = edgeCnt;
      lastLat   = bus.md_div_e ? 10 : 5;
    end
`ifdef HAZARD_STATS_EN
    if (bus.stats_clr) begin
      mStall = 0; mLoad = 0; mMd = 0;
    end else begin
      mStall += {31'd0, h[4]}; mLoad += {31'd0, h[3]}; mMd += {31'd0, h[1]};
    end
`else
    h = '0;
`endif
    #1;
  endtask

  task automatic checkModel(input string tag);
    logic [4:0] h;
    h = refHaz(modelBusy());
    chk({tag, ".fwd_e"},   32'(bus.fwd_e),   32'(refFwdE()));
    chk({tag, ".fwd_d"},   32'(bus.fwd_d),   32'(refFwdD()));
    chk({tag, ".stall_f"}, 32'(bus.stall_f), 32'(h[4]));
    chk({tag, ".stall_d"}, 32'(bus.stall_d), 32'(h[4]));
    chk({tag, ".flush_e"}, 32'(bus.flush_e), 32'(h[4]));
    chk({tag, ".md_busy"}, 32'(bus.md_busy), 32'(modelBusy()));
  endtask

  task automatic checkStall(input string tag, input logic expStall, input logic expBusy);
    chk({tag, ".stall"},   32'(bus.stall_d), 32'(expStall));
    chk({tag, ".flush"},   32'(bus.flush_e), 32'(expStall));
    chk({tag, ".md_busy"}, 32'(bus.md_busy), 32'(expBusy));
  endtask

  vec_t tbl[14];
  vec_t idle;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle = '{"idle", 10'd0, 2'b00, 0, 0, 10'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 4'b0, 2'b0, 0};
    tbl[0]  = '{"fwd_mw",      10'd0, 2'b00, 0, 0, {5'd9, 5'd8}, 5'd0, 0, 0, 0, 0, 5'd8, 1, 0, 5'd9, 1, 4'b0110, 2'b00, 0};
    tbl[1]  = '{"fwd_zero",    10'd0, 2'b00, 0, 0, 10'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 0, 5'd0, 1, 4'b0000, 2'b00, 0};
    tbl[2]  = '{"m_beats_w",   10'd0, 2'b00, 0, 0, {5'd5, 5'd5}, 5'd0, 0, 0, 0, 0, 5'd5, 1, 0, 5'd5, 1, 4'b1010, 2'b00, 0};
    tbl[3]  = '{"load_use",    {5'd4, 5'd0}, 2'b10, 0, 0, 10'd0, 5'd4, 1, 1, 0, 0, 5'd0, 0, 0, 5'd0, 0, 4'b0000, 2'b00, 1};
    tbl[4]  = '{"load_unused", {5'd4, 5'd0}, 2'b01, 0, 0, 10'd0, 5'd4, 1, 1, 0, 0, 5'd0, 0, 0, 5'd0, 0, 4'b0000, 2'b00, 0};
    tbl[5]  = '{"load_r0",     10'd0, 2'b11, 0, 0, 10'd0, 5'd0, 1, 1, 0, 0, 5'd0, 0, 0, 5'd0, 0, 4'b0000, 2'b00, 0};
    tbl[6]  = '{"br_e",        {5'd0, 5'd3}, 2'b01, 1, 0, 10'd0, 5'd3, 1, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 4'b0000, 2'b00, 1};
    tbl[7]  = '{"br_fwd_m",    {5'd0, 5'd3}, 2'b01, 1, 0, 10'd0, 5'd0, 0, 0, 0, 0, 5'd3, 1, 0, 5'd0, 0, 4'b0000, 2'b01, 0};
    tbl[8]  = '{"br_load_m",   {5'd0, 5'd3}, 2'b01, 1, 0, 10'd0, 5'd0, 0, 0, 0, 0, 5'd3, 1, 1, 5'd0, 0, 4'b0000, 2'b00, 1};
    tbl[9]  = '{"br_r0",       10'd0, 2'b11, 1, 0, 10'd0, 5'd0, 1, 0, 0, 0, 5'd0, 1, 0, 5'd0, 0, 4'b0000, 2'b00, 0};
    tbl[10] = '{"load_m_to_e", {5'd4, 5'd0}, 2'b10, 0, 0, {5'd4, 5'd0}, 5'd0, 0, 0, 0, 0, 5'd4, 1, 1, 5'd0, 0, 4'b1000, 2'b00, 0};
    tbl[11] = '{"br_unused",   {5'd0, 5'd3}, 2'b00, 1, 0, 10'd0, 5'd3, 1, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 4'b0000, 2'b00, 0};
    tbl[12] = '{"md_idle",     10'd0, 2'b00, 0, 1, 10'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 4'b0000, 2'b00, 0};
    tbl[13] = '{"fwd_d_both",  {5'd7, 5'd7}, 2'b11, 0, 0, 10'd0, 5'd0, 0, 0, 0, 0, 5'd7, 1, 0, 5'd0, 0, 4'b0000, 2'b11, 0};

    rst_n = 1'b0;
    applyVec(idle);
`ifdef HAZARD_STATS_EN
    bus.stats_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset.md_busy", 32'(bus.md_busy), 32'd0);
    chk("reset.stall",   32'(bus.stall_d), 32'd0);
    chk("reset.fwd_e",   32'(bus.fwd_e),   32'd0);
`ifdef HAZARD_STATS_EN
    chk("reset.stall_cycles", bus.stall_cycles, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      applyVec(tbl[i]);
      #1;
      chk({tbl[i].name, ".fwd_e"},   32'(bus.fwd_e),   32'(tbl[i].expFwdE));
      chk({tbl[i].name, ".fwd_d"},   32'(bus.fwd_d),   32'(tbl[i].expFwdD));
      chk({tbl[i].name, ".stall_f"}, 32'(bus.stall_f), 32'(tbl[i].expStall));
      chk({tbl[i].name, ".stall_d"}, 32'(bus.stall_d), 32'(tbl[i].expStall));
      chk({tbl[i].name, ".flush_e"}, 32'(bus.flush_e), 32'(tbl[i].expStall));
      tick();
    end

    // Mult issued at edge 0 with a HI/LO consumer held in D.
    applyVec(idle);
    bus.md_use_d = 1; bus.md_start_e = 1; bus.md_div_e = 0;
    #1;
    checkStall("mul.c0", 1, 0);
    tick();
    bus.md_start_e = 0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      checkStall($sformatf("mul.c%0d", c), 1, 1);
      tick();
    end
    #1;
    checkStall("mul.c6", 0, 0);
    bus.md_use_d = 0;
    tick();

    // Div at edge 0, reissued at edge 3: busy through edge 12.
    bus.md_start_e = 1; bus.md_div_e = 1;
    tick();
    bus.md_start_e = 0;
    for (int e = 1; e <= 14; e++) begin
      if (e == 3) bus.md_start_e = 1;
      #1;
      chk($sformatf("div.e%0d.md_busy", e - 1), 32'(bus.md_busy), 32'(e - 1 < 13));
      tick();
      bus.md_start_e = 0;
    end

    // Reset in the middle of a div.
    bus.md_start_e = 1; bus.md_div_e = 1;
    tick();
    bus.md_start_e = 0;
    repeat (3) tick();
    bus.md_use_d = 1;
    #1;
    checkStall("rstdiv.before", 1, 1);
    rst_n = 1'b0;
    #1;
    checkStall("rstdiv.after", 0, 0);
`ifdef HAZARD_STATS_EN
    chk("rstdiv.stall_cycles", bus.stall_cycles, 32'd0);
    chk("rstdiv.load_use_cnt", bus.load_use_cnt, 32'd0);
    chk("rstdiv.md_wait_cnt",  bus.md_wait_cnt,  32'd0);
`endif
    lastStart = -100;
    mStall = 0; mLoad = 0; mMd = 0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.md_use_d = 0;
    tick();

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      bus.src_d = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      bus.src_e = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      bus.use_d = 2'($urandom);
      bus.br_d = 1'($urandom);
      bus.md_use_d = ($urandom_range(0, 2) == 0);
      bus.dst_e = 5'($urandom_range(0, 3));
      bus.wen_e = 1'($urandom);
      bus.load_e = 1'($urandom);
      bus.md_start_e = ($urandom_range(0, 9) == 0);
      bus.md_div_e = 1'($urandom);
      bus.dst_m = 5'($urandom_range(0, 3));
      bus.wen_m = 1'($urandom);
      bus.load_m = 1'($urandom);
      bus.dst_w = 5'($urandom_range(0, 3));
      bus.wen_w = 1'($urandom);
      #1;
      checkModel($sformatf("rand%0d", n));
      tick();
    end

`ifdef HAZARD_STATS_EN
    #1;
    chk("stats.stall_cycles", bus.stall_cycles, mStall);
    chk("stats.load_use_cnt", bus.load_use_cnt, mLoad);
    chk("stats.md_wait_cnt",  bus.md_wait_cnt,  mMd);
    bus.stats_clr = 1;
    bus.load_e = 1; bus.dst_e = 5'd2; bus.src_d = {5'd2, 5'd2}; bus.use_d = 2'b11;
    tick();
    bus.stats_clr = 0;
    chk("clr.stall_cycles", bus.stall_cycles, 32'd0);
    chk("clr.load_use_cnt", bus.load_use_cnt, 32'd0);
    tick();
    chk("post_clr.load_use_cnt", bus.load_use_cnt, mLoad);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
